// File: rtl/ds_pkg.sv
// Shared encodings for the differential serialiser: line modes, FSM states
// and the PRBS7 generator.
package ds_pkg;

    typedef enum logic [1:0] {
        MODE_DATA = 2'b00,
        MODE_PRBS = 2'b01,
        MODE_CLK  = 2'b10,
        MODE_IDLE = 2'b11
    } ds_mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StData = 2'b01,
        StTest = 2'b10
    } ds_state_e;

    localparam logic [6:0] PrbsSeed = 7'h7F;

    // x^7 + x^6 + 1, shifting towards the msb which is the output bit
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/ds_obuf.sv
// Bank of differential output buffers, one per lane, driving the pins directly.
module ds_obuf #(
    parameter int unsigned D_W = 4
) (
    input  logic [D_W-1:0] din,
    output logic [D_W-1:0] pad_p,
    output logic [D_W-1:0] pad_n
);

    for (genvar k = 0; k < D_W; k++) begin : g_lane
        ds_obufds_cell u_cell (
            .i  (din[k]),
            .o  (pad_p[k]),
            .ob (pad_n[k])
        );
    end

endmodule

// File: rtl/ds_obufds_cell.sv
// Behavioural model of the vendor differential output buffer primitive.
// Replaced by the technology cell of the same port shape in implementation.
module ds_obufds_cell (
    input  logic i,
    output logic o,
    output logic ob
);

    assign o  = i;
    assign ob = ~i;

endmodule

// File: rtl/ds_ser_o.sv
// Multi-lane LSB-first serialiser with PRBS7 / clock test patterns, per-lane
// polarity inversion and a registered bit feeding the differential buffers.
module ds_ser_o
    import ds_pkg::*;
#(
    parameter int unsigned D_W      = 4,
    parameter int unsigned SER_W    = 10,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [D_W*SER_W-1:0] dat_i,
    input  logic                 vld_i,
    output logic                 rdy_o,
    input  logic [1:0]           mode_i,
    input  logic [D_W-1:0]       inv_i,
    output logic                 urun_o,
    output logic [D_W-1:0]       dat_p_o,
    output logic [D_W-1:0]       dat_n_o
);

    localparam int unsigned      CntW    = $clog2(SER_W);
    localparam logic [CntW-1:0]  CntMax  = CntW'(SER_W - 1);
    localparam logic [CntW-1:0]  CntHalf = CntW'(SER_W / 2);

    ds_state_e              state_q, state_d;
    ds_mode_e               mode_q, mode_new;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [D_W*SER_W-1:0]   shreg_q, shreg_d, shreg_src;
    logic [6:0]             lfsr_q, lfsr_d;
    logic [D_W-1:0]         out_q, out_d, serial;
    logic                   urun_q, urun_d;
    logic                   last, sample_en, xfer, test_mode, data_act, pat;

    assign last      = (cnt_q == CntMax);
    // Mode is only picked up between frames, so a frame always finishes in its own mode
    assign sample_en = (state_q == StIdle) || last;
    assign mode_new  = sample_en ? ds_mode_e'(mode_i) : mode_q;
    assign test_mode = (mode_new == MODE_PRBS) || (mode_new == MODE_CLK);
    assign xfer      = vld_i & rdy_o;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StData;
                end else if (test_mode) begin
                    state_d = StTest;
                end
            end
            StData: begin
                if (last && !xfer) begin
                    state_d = StIdle;
                end
            end
            StTest: begin
                if (last && !test_mode) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: ready window and underrun detection
    always_comb begin
        rdy_o  = 1'b0;
        urun_d = 1'b0;
        if (!rst_i && mode_new == MODE_DATA) begin
            rdy_o = (state_q == StIdle) || (state_q == StData && last);
        end
        // A deliberate switch away from data mode at frame end is not an underrun
        if (state_q == StData && last && !vld_i && mode_new == MODE_DATA) begin
            urun_d = 1'b1;
        end
    end

    // Datapath next state: shifter, bit counter, LFSR and serial bit select
    always_comb begin
        shreg_src = xfer ? dat_i : shreg_q;
        shreg_d   = shreg_q;
        serial    = {D_W{IDLE_BIT}};
        cnt_d     = (state_q == StIdle || last) ? '0 : cnt_q + 1'b1;
        lfsr_d    = lfsr_q;
        pat       = IDLE_BIT;

        if (state_q == StTest && mode_q == MODE_PRBS) begin
            lfsr_d = prbs7_next(lfsr_q);
        end

        case (mode_q)
            MODE_PRBS: pat = lfsr_q[6];
            MODE_CLK:  pat = (cnt_q < CntHalf);
            default:   pat = IDLE_BIT;
        endcase

        // bit0 of an accepted word goes out in the transfer cycle itself, which
        // gives one-cycle latency and a gapless reload at bit_cnt == SER_W-1
        data_act = xfer || (state_q == StData && !last);

        for (int k = 0; k < D_W; k++) begin
            if (xfer || state_q == StData) begin
                shreg_d[k*SER_W +: SER_W] = {1'b0, shreg_src[k*SER_W+1 +: SER_W-1]};
            end
            if (state_q == StTest) begin
                serial[k] = pat;
            end else if (data_act) begin
                serial[k] = shreg_src[k*SER_W];
            end else begin
                serial[k] = IDLE_BIT;
            end
        end

        out_d = serial ^ inv_i;
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            mode_q  <= MODE_DATA;
            lfsr_q  <= PrbsSeed;
            urun_q  <= 1'b0;
            out_q   <= {D_W{IDLE_BIT}} ^ inv_i;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            mode_q  <= mode_new;
            lfsr_q  <= lfsr_d;
            urun_q  <= urun_d;
            out_q   <= out_d;
        end
    end

    assign urun_o = urun_q;

    ds_obuf #(
        .D_W (D_W)
    ) u_obuf (
        .din   (out_q),
        .pad_p (dat_p_o),
        .pad_n (dat_n_o)
    );

endmodule

// File: tb/tb_ds_ser_o.sv
// Directed self-checking bench for ds_ser_o (D_W=4, SER_W=10, IDLE_BIT=0).
module tb_ds_ser_o;

    localparam int unsigned D_W   = 4;
    localparam int unsigned SER_W = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [D_W*SER_W-1:0] dat;
    logic                 vld;
    logic                 rdy;
    logic [1:0]           mode;
    logic [D_W-1:0]       inv;
    logic                 urun;
    logic [D_W-1:0]       dat_p;
    logic [D_W-1:0]       dat_n;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ds_ser_o #(
        .D_W      (D_W),
        .SER_W    (SER_W),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .dat_i   (dat),
        .vld_i   (vld),
        .rdy_o   (rdy),
        .mode_i  (mode),
        .inv_i   (inv),
        .urun_o  (urun),
        .dat_p_o (dat_p),
        .dat_n_o (dat_n)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit b of every lane of a parallel word
    function automatic logic [D_W-1:0] col(input logic [D_W*SER_W-1:0] w, input int b);
        logic [D_W-1:0] r;
        for (int k = 0; k < D_W; k++) r[k] = w[k*SER_W + b];
        return r;
    endfunction

    logic [D_W*SER_W-1:0] words [3];
    logic [D_W*SER_W-1:0] got_w [3];
    int                   rdy_at [3];
    logic [D_W-1:0]       nexp;
    logic [9:0]           seq;
    logic [6:0]           lfsr;
    logic                 prbs_bits [254];
    logic                 prbs_exp  [254];

    initial begin
        int cnt_a, cnt_b, cnt_c, xi;

        words[0] = {10'h0F0, 10'h2A5, 10'h155, 10'h2A5};
        words[1] = {10'h3FF, 10'h001, 10'h200, 10'h0CC};
        words[2] = {10'h123, 10'h000, 10'h1E1, 10'h3A8};

        // Reset state
        rst = 1'b1; vld = 1'b0; mode = 2'b00; inv = '0; dat = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_p", dat_p, 4'h0);
        chk("rst_n", dat_n, 4'hF);
        chk("rst_urun", urun, 1'b0);
        inv = 4'b0101;
        @(negedge clk); #1;
        chk("rst_inv_p", dat_p, 4'b0101);
        chk("rst_inv_n", dat_n, 4'b1010);
        inv = '0;
        @(negedge clk);

        // Single word, then underrun
        rst = 1'b0; vld = 1'b1; dat = words[0];
        #1;
        chk("w_rdy_idle", rdy, 1'b1);
        cnt_a = 0; seq = '0;
        for (int s = 1; s <= 12; s++) begin
            @(negedge clk);
            vld = 1'b0;
            #1;
            nexp = ~dat_p;
            if (s <= 10) begin
                chk($sformatf("w_bit%0d", s - 1), dat_p, col(words[0], s - 1));
                chk($sformatf("w_comp%0d", s - 1), dat_n, nexp);
                seq[s-1] = dat_p[0];
            end
            if (s <= 9 && rdy) cnt_a++;
            if (s == 10) chk("w_rdy_last", rdy, 1'b1);
            if (s == 11) begin
                chk("urun_pulse", urun, 1'b1);
                chk("urun_idle_p", dat_p, 4'h0);
            end
            if (s == 12) begin
                chk("urun_once", urun, 1'b0);
                chk("urun_rdy", rdy, 1'b1);
                chk("urun_idle_n", dat_n, 4'hF);
            end
        end
        chk("w_lane0", seq, 10'h2A5);
        chk("w_rdy_mid", cnt_a, 0);

        // Back-to-back words
        xi = 0; cnt_a = 0; cnt_b = 0;
        for (int s = 0; s <= 31; s++) begin
            @(negedge clk);
            if (xi < 3) begin
                vld = 1'b1; dat = words[xi];
            end else begin
                vld = 1'b0; dat = '0;
            end
            #1;
            if (s >= 1 && s <= 30) begin
                for (int k = 0; k < D_W; k++) got_w[(s-1)/10][k*SER_W + (s-1)%10] = dat_p[k];
                if (urun) cnt_b++;
            end
            if (s <= 29 && rdy) cnt_a++;
            if (rdy && vld) begin
                rdy_at[xi] = s;
                xi++;
            end
            if (s == 31) chk("b2b_urun_end", urun, 1'b1);
        end
        chk("b2b_rdy_cnt", cnt_a, 3);
        chk("b2b_rdy0", rdy_at[0], 0);
        chk("b2b_rdy1", rdy_at[1], 10);
        chk("b2b_rdy2", rdy_at[2], 20);
        chk("b2b_urun", cnt_b, 0);
        for (int w = 0; w < 3; w++) chk($sformatf("b2b_word%0d", w), got_w[w], words[w]);

        // PRBS7 from reset
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; mode = 2'b01;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("prbs_rdy", rdy, 1'b0);
        @(negedge clk); #1;
        chk("prbs_lead", dat_p, 4'h0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 254; i++) begin
            @(negedge clk); #1;
            prbs_bits[i] = dat_p[0];
            if (dat_p !== {D_W{dat_p[0]}}) cnt_a++;
            nexp = ~dat_p;
            if (dat_n !== nexp) cnt_b++;
        end
        seq = '0;
        for (int i = 0; i < 8; i++) seq[i] = prbs_bits[i];
        chk("prbs_first8", seq[7:0], 8'h7F);
        chk("prbs_lanes", cnt_a, 0);
        chk("prbs_comp", cnt_b, 0);
        lfsr = 7'h7F;
        for (int i = 0; i < 254; i++) begin
            prbs_exp[i] = lfsr[6];
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 254; i++) if (prbs_bits[i] !== prbs_exp[i]) cnt_a++;
        for (int i = 0; i < 127; i++) if (prbs_bits[i] !== prbs_bits[i+127]) cnt_b++;
        chk("prbs_model", cnt_a, 0);
        chk("prbs_period", cnt_b, 0);

        // Clock pattern, switched to data mode mid-frame
        @(negedge clk);
        rst = 1'b1; mode = 2'b10;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("clk_lead", dat_p, 4'h0);
        cnt_a = 0; seq = '0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (j == 3) mode = 2'b00;
            #1;
            if (j <= 10) seq[10-j] = dat_p[0];
            if (j == 1) chk("clk_all_lanes", dat_p, 4'hF);
            if (j <= 9 && rdy) cnt_a++;
            if (j == 10) chk("clk_rdy_after", rdy, 1'b1);
            if (j == 11) chk("clk_idle_p", dat_p, 4'h0);
        end
        chk("clk_frame", seq, 10'b1111100000);
        chk("clk_rdy_mid", cnt_a, 0);

        // Lane inversion mid-word, then reset mid-frame
        @(negedge clk);
        vld = 1'b1; dat = words[0]; inv = '0;
        #1;
        chk("inv_rdy", rdy, 1'b1);
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            vld = 1'b0;
            if (s == 3) inv = 4'b0100;
            #1;
            if (s == 3) chk("inv_pre", dat_p, col(words[0], 2));
            if (s == 4) chk("inv_post", dat_p, col(words[0], 3) ^ 4'b0100);
            if (s == 5) chk("inv_hold", dat_p, col(words[0], 4) ^ 4'b0100);
        end
        rst = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk); #1;
            chk($sformatf("mid_rst_p%0d", r), dat_p, 4'b0100);
            chk($sformatf("mid_rst_rdy%0d", r), rdy, 1'b0);
            chk($sformatf("mid_rst_urun%0d", r), urun, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0; vld = 1'b1; dat = words[1];
        #1;
        chk("rel_rdy", rdy, 1'b1);
        cnt_a = 0; cnt_b = 0;
        for (int s = 1; s <= 10; s++) begin
            @(negedge clk);
            vld = 1'b0;
            #1;
            if (dat_p !== (col(words[1], s - 1) ^ 4'b0100)) cnt_a++;
            if (urun) cnt_b++;
        end
        chk("rel_frame", cnt_a, 0);
        chk("rel_no_urun", cnt_b, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ds_ser_o.md
DS_SER_O -- requirements
Module: ds_ser_o

Interface
REQ-001 Parameter D_W, default 4: number of differential lanes.
REQ-002 Parameter SER_W, default 10: serialisation ratio in bits per word per lane; even, at least 4.
REQ-003 Parameter IDLE_BIT, default 1'b0: line level driven per lane when no data is available.
REQ-004 Port clk_i, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Port dat_i, input, D_W*SER_W: parallel words; lane k occupies bits [k*SER_W +: SER_W].
REQ-007 Port vld_i, input, 1: dat_i valid.
REQ-008 Port rdy_o, output, 1: block accepts dat_i this cycle.
REQ-009 Port mode_i, input, 2: 00 data, 01 PRBS7, 10 clock pattern, 11 forced idle.
REQ-010 Port inv_i, input, D_W: per-lane polarity inversion.
REQ-011 Port urun_o, output, 1: one-cycle pulse on data underrun.
REQ-012 Port dat_p_o / dat_n_o, output, D_W each: differential lane outputs, connected directly to top-level pins.

Function
REQ-013 The state machine SHALL have three states: IDLE, DATA and TEST.
REQ-014 The bit counter bit_cnt SHALL count 0..SER_W-1 and wrap to 0; one frame is SER_W cycles.
REQ-015 A transfer SHALL occur when vld_i and rdy_o are both high in the same cycle.
REQ-016 rdy_o SHALL be combinational: high in IDLE when the mode is 00, and high in DATA when bit_cnt == SER_W-1 and the mode is 00; low otherwise.
REQ-017 The mode SHALL be sampled into mode_q only in IDLE or at bit_cnt == SER_W-1; mode_i changes mid-frame SHALL NOT affect the current frame.
REQ-018 IDLE with mode_q 00: a transfer SHALL load the shift register, clear bit_cnt and enter DATA.
REQ-019 IDLE with mode_q 01 or 10: the block SHALL enter TEST with bit_cnt = 0.
REQ-020 DATA: the block SHALL shift LSB-first, one bit per lane per cycle.
REQ-021 DATA at bit_cnt == SER_W-1 with a transfer: the next word SHALL load seamlessly, with no gap cycle.
REQ-022 DATA at bit_cnt == SER_W-1 with no transfer: the block SHALL go to IDLE and pulse urun_o for exactly one cycle.
REQ-023 TEST at bit_cnt == SER_W-1: the block SHALL go to IDLE if the newly sampled mode is 00 or 11, otherwise stay in TEST.
REQ-024 A pattern bit in TEST SHALL be produced every cycle; dat_i and vld_i are ignored and rdy_o = 0.
REQ-025 PRBS7 SHALL use x^7+x^6+1, seed 7'h7F, and output the LFSR msb; the same bit is driven on all lanes.
REQ-026 The PRBS7 LFSR SHALL advance only in TEST with mode_q 01, keep its state across frames, and reseed only on reset.
REQ-027 The clock pattern SHALL be 1 for bit_cnt < SER_W/2 and 0 otherwise.
REQ-028 In IDLE and with mode 11, the serial bit SHALL be IDLE_BIT; no transfers are accepted and urun_o is not asserted.
REQ-029 Each lane's pre-buffer bit SHALL be registered: bit XOR inv_i[k]. inv_i acts on the next cycle, independent of frame boundaries.
REQ-030 Latency SHALL be: a transfer at cycle t puts bit0 on dat_p_o at t+1 and bit SER_W-1 at t+SER_W.
REQ-031 dat_n_o SHALL always be the complement of dat_p_o.

Reset
REQ-032 While rst_i is high, the block SHALL set: state IDLE, bit_cnt 0, shift register 0, mode_q 00, LFSR 7'h7F, urun_o 0, output register IDLE_BIT XOR inv_i.
REQ-033 rdy_o SHALL be 0 while rst_i is high.
REQ-034 rst_i asserted mid-frame SHALL abort the frame with no underrun pulse; the first transfer can occur in the first cycle after rst_i deasserts.

Structure
REQ-035 Package ds_pkg SHALL hold the mode encodings (MODE_DATA, MODE_PRBS, MODE_CLK, MODE_IDLE), the state encodings and the PRBS seed constant.
REQ-036 Sub-module ds_obuf SHALL contain the D_W vendor differential output-buffer instances and no other logic.
REQ-037 All other logic SHALL reside in ds_ser_o.

Verification
REQ-038 D_W=4, SER_W=10; lane0 word 10'h2A5 accepted at t: dat_p_o[0] = 1,0,1,0,0,1,0,1,0,1 over t+1..t+10; dat_n_o is the complement throughout.
REQ-039 Back-to-back words with vld_i held high: rdy_o pulses every 10 cycles, there is no gap bit, and urun_o stays 0.
REQ-040 vld_i dropped after one word: urun_o pulses once at frame end, then all lanes hold IDLE_BIT and rdy_o = 1.
REQ-041 mode_i=01 from reset: the first 7 bits are 1,1,1,1,1,1,1; the sequence repeats with period 127; it is identical on all lanes.
REQ-042 mode_i switched 10->00 at bit_cnt 3: the clock pattern completes its frame (1111100000), then rdy_o = 1.
REQ-043 inv_i[2] toggled mid-word, then rst_i pulsed at bit_cnt 5: lane 2 inverts one cycle later; after reset, outputs equal IDLE_BIT XOR inv_i and urun_o = 0.
